// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizes for the fetch/data memory arbiter.
package mem_arbiter_pkg;

   localparam int DEF_ADDR_W       = 8;
   localparam int DEF_DATA_W       = 8;
   localparam int DEF_STARVE_LIMIT = 4;

   // Which port the read data on mem_rdata belongs to in the current cycle
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch port, the data port, the single-port memory
// and the arbiter. The arbiter uses the slave view; requesters and the
// memory model sit on the master view.
interface mem_arbiter_if #(
   parameter int ADDR_W = mem_arbiter_pkg::DEF_ADDR_W,
   parameter int DATA_W = mem_arbiter_pkg::DEF_DATA_W
);
   // fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_valid;
   logic [DATA_W-1:0] if_rdata;
   logic              stall_if;

   // data port
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_valid;
   logic [DATA_W-1:0] d_rdata;

   // memory side
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_valid, if_rdata, stall_if,
      output d_gnt, d_valid, d_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_valid, if_rdata, stall_if,
      input  d_gnt, d_valid, d_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Fetch starvation guard: counts consecutive data grants made while fetch is
// waiting, saturating at STARVE_LIMIT. Used only when MEM_ARB_STARVE_GUARD_EN
// is defined. 'starve' tells the arbiter to hand the next slot to fetch.
module mem_arb_starve_cnt import mem_arbiter_pkg::*; #(
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic clk,
   input  logic reset,
   input  logic if_req,
   input  logic if_gnt,
   input  logic d_gnt,
   output logic starve
);

   localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   // Clear when fetch stops waiting or gets served; otherwise count data wins
   always_comb begin
      cnt_next = cnt_reg;
      if (!if_req || if_gnt) begin
         cnt_next = '0;
      end else if (d_gnt && (cnt_reg != LIMIT_C)) begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign starve = if_req && (cnt_reg == LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port synchronous memory.
// Data requests normally win because they belong to the older instruction.
// Read data returns one cycle after the grant; a response-owner register
// steers it to the correct port. Optional macro MEM_ARB_STARVE_GUARD_EN adds
// a counter that forces a fetch grant after STARVE_LIMIT consecutive data
// grants while fetch waits.
module mem_arbiter import mem_arbiter_pkg::*; #(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);

   owner_e            owner_reg;
   owner_e            owner_next;
   logic              if_gnt;
   logic              d_gnt;
   logic              fetch_first;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] if_rdata_reg;
   logic [DATA_W-1:0] d_rdata_reg;

`ifdef MEM_ARB_STARVE_GUARD_EN
   mem_arb_starve_cnt #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk    (clk),
      .reset  (reset),
      .if_req (bus.if_req),
      .if_gnt (if_gnt),
      .d_gnt  (d_gnt),
      .starve (fetch_first)
   );
`else
   // Strict data priority: fetch can wait indefinitely behind data traffic
   assign fetch_first = 1'b0;
`endif

   // Arbitration, memory request mux and next response owner
   always_comb begin
      if_gnt     = 1'b0;
      d_gnt      = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = bus.d_addr;
      mem_wdata  = bus.d_wdata;
      owner_next = OWN_NONE;
      if (!reset) begin
         if (bus.d_req && !fetch_first) begin
            d_gnt      = 1'b1;
            mem_en     = 1'b1;
            mem_we     = bus.d_we;
            owner_next = bus.d_we ? OWN_NONE : OWN_D;
         end else if (bus.if_req) begin
            if_gnt     = 1'b1;
            mem_en     = 1'b1;
            mem_addr   = bus.if_addr;
            owner_next = OWN_IF;
         end
      end
   end

   // Response owner: remembers whose read is returning next cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_reg <= OWN_NONE;
      end else begin
         owner_reg <= owner_next;
      end
   end

   // Capture returned data so each port's rdata holds while valid is low
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_rdata_reg <= '0;
         d_rdata_reg  <= '0;
      end else begin
         if (owner_reg == OWN_IF) begin
            if_rdata_reg <= bus.mem_rdata;
         end
         if (owner_reg == OWN_D) begin
            d_rdata_reg <= bus.mem_rdata;
         end
      end
   end

   assign bus.if_gnt    = if_gnt;
   assign bus.d_gnt     = d_gnt;
   assign bus.stall_if  = bus.if_req && !if_gnt;
   assign bus.mem_en    = mem_en;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;

   // Data is visible in the response cycle itself, then held from the register
   assign bus.if_valid  = (owner_reg == OWN_IF);
   assign bus.d_valid   = (owner_reg == OWN_D);
   assign bus.if_rdata  = (owner_reg == OWN_IF) ? bus.mem_rdata : if_rdata_reg;
   assign bus.d_rdata   = (owner_reg == OWN_D)  ? bus.mem_rdata : d_rdata_reg;

endmodule
